pipe_ctrl: RTL and testbench
============================

Name: pipe_ctrl

Overview:
- Pipeline sequencing controller for the 6-stage RISC-V core: pc, if, id, ex, mem, wb.
- Arbitrates stall requests from if, id (load-use hazard) and mem (data-port busy) into one per-stage stall vector.
- Schedules branch/jump redirects from ex as a flush plus a new PC. A redirect that arrives while mem is stalling is deferred until the stall clears.
- Monitors mem stall length and raises a sticky timeout.

Parameters:
- MAX_STALL, 64: consecutive mem-stall cycles before stall_timeout_o sets. Legal range 2..65535.
- CNT_W, 16: width of the internal stall-run counter. Must satisfy 2^CNT_W > MAX_STALL.

Ports:
- clk  input  1  core clock; all state updates on rising edge.
- rst  input  1  asynchronous, active-low reset.
- stallreq_if_i  input  1  instruction fetch not ready.
- stallreq_id_i  input  1  load-use hazard detected in decode.
- stallreq_mem_i  input  1  data memory access not complete.
- branch_flag_i  input  1  ex resolved a taken branch/jump this cycle.
- branch_target_i  input  32  redirect address, valid with branch_flag_i.
- stall_o  output  6  per-stage hold: bit0 pc, bit1 if, bit2 id, bit3 ex, bit4 mem, bit5 wb.
- flush_o  output  1  kill if/id contents (one-cycle pulse).
- new_pc_o  output  32  redirect address, valid while flush_o=1.
- stall_timeout_o  output  1  sticky mem-stall timeout flag.
- perf_stall_cycles_o  output  32  optional performance counter.
- perf_flush_count_o  output  32  optional performance counter.

Behaviour:
- Reset (rst=0, asynchronous):
  - FSM goes to IDLE; target register, stall-run counter and perf counters clear to 0.
  - All outputs read 0 while reset is asserted.
- stall_o is combinational from the requests. Priority mem > id > if:
  - mem: 6'b011111 (wb proceeds, pc..mem held).
  - id: 6'b000111 (ex receives a bubble).
  - if: 6'b000011.
  - none: 6'b000000.
- FSM states: IDLE, HOLD.
- IDLE, branch_flag_i=1 and stallreq_mem_i=0:
  - Same cycle: flush_o=1, new_pc_o=branch_target_i, stall_o forced to 0 (the flush overrides id/if requests).
  - Remain in IDLE.
- IDLE, branch_flag_i=1 and stallreq_mem_i=1:
  - Latch branch_target_i into the target register; go to HOLD.
  - flush_o=0; stall_o=011111.
- HOLD, stallreq_mem_i=1:
  - Remain in HOLD; flush_o=0.
  - branch_flag_i is ignored (ex is held, so the flag repeats for the same instruction).
  - The target register is not overwritten.
- HOLD, stallreq_mem_i=0:
  - flush_o=1, new_pc_o=latched target, stall_o=0; go to IDLE.
  - branch_flag_i in this cycle is the same held instruction and is ignored. It must not produce a second flush.
- new_pc_o is 0 whenever flush_o=0.
- Stall-run counter:
  - Increments each cycle stallreq_mem_i=1; saturates at MAX_STALL.
  - Clears to 0 on any cycle with stallreq_mem_i=0.
- stall_timeout_o:
  - Sets on the rising edge where the counter equals MAX_STALL-1 and stallreq_mem_i=1. The flag is visible the cycle after the MAX_STALL-th consecutive stall cycle.
  - Stays set until reset; it is not cleared when the stall ends.
- Reset asserted mid-HOLD: the pending redirect is discarded and no flush is emitted after reset releases.
- Simultaneous if, id and mem requests: the mem vector wins; no request is queued.

Optional Feature:
- Macro: PIPE_CTRL_PERF_EN.
- Defined:
  - perf_stall_cycles_o increments each cycle stall_o != 0.
  - perf_flush_count_o increments each cycle flush_o=1.
  - Both are 32-bit, wrap modulo 2^32 and reset to 0.
- Undefined: both ports are tied to 32'h0 and no counter flops are synthesized.

Test Plan:
- Reset then idle, no requests: stall_o=000000, flush_o=0, new_pc_o=0, stall_timeout_o=0.
- Priority arbitration:
  - stallreq_id_i=1 and stallreq_if_i=1 together: stall_o=000111.
  - Then add stallreq_mem_i=1: stall_o=011111.
- Immediate redirect: branch_flag_i=1, target 32'h0000_0100, stallreq_id_i=1, no mem stall → same cycle flush_o=1, new_pc_o=32'h100, stall_o=000000; next cycle with branch_flag_i=0, flush_o=0.
- Deferred redirect:
  - stallreq_mem_i=1 for 3 cycles; branch_flag_i=1 held with target 32'h0000_2000 (changed to 32'hDEAD on cycle 2, not recaptured).
  - Response: flush_o=0 for all 3 cycles; on the release cycle, exactly one flush_o pulse with new_pc_o=32'h2000.
- Timeout, MAX_STALL=4:
  - stallreq_mem_i=1 for 4 cycles → stall_timeout_o=1 from cycle 5.
  - Drop stallreq_mem_i: the flag stays 1.
  - Repeat with a 3-cycle stall from reset → the flag stays 0.
- Reset mid-HOLD, with PIPE_CTRL_PERF_EN defined:
  - Reset during HOLD → no flush after release; perf counters read 0.
  - Then 2 stall cycles and 1 flush → perf_stall_cycles_o=2, perf_flush_count_o=1.

Source files
------------

// File: rtl/pipe_ctrl.sv
// Pipeline sequencing controller: stall arbitration, branch redirect scheduling
// and mem-stall timeout. Optional perf counters enabled by PIPE_CTRL_PERF_EN.
module pipe_ctrl #(
  parameter int MAX_STALL = 64,
  parameter int CNT_W     = 16
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        stallreq_if_i,
  input  logic        stallreq_id_i,
  input  logic        stallreq_mem_i,
  input  logic        branch_flag_i,
  input  logic [31:0] branch_target_i,
  output logic [5:0]  stall_o,
  output logic        flush_o,
  output logic [31:0] new_pc_o,
  output logic        stall_timeout_o,
  output logic [31:0] perf_stall_cycles_o,
  output logic [31:0] perf_flush_count_o
);

  localparam logic [CNT_W-1:0] MAX_CNT = CNT_W'(MAX_STALL);

  localparam logic [5:0] STALL_MEM  = 6'b011111;
  localparam logic [5:0] STALL_ID   = 6'b000111;
  localparam logic [5:0] STALL_IF   = 6'b000011;
  localparam logic [5:0] STALL_NONE = 6'b000000;

  typedef enum logic {IDLE, HOLD} state_t;

  state_t      state_q, state_d;
  logic [31:0] target_q;
  logic        capture;
  logic [5:0]  stall_req;
  logic [5:0]  stall_d;
  logic        flush_d;
  logic [31:0] new_pc_d;
  logic [CNT_W-1:0] run_cnt_q;
  logic        timeout_q;

  always_comb begin
    if (stallreq_mem_i)     stall_req = STALL_MEM;
    else if (stallreq_id_i) stall_req = STALL_ID;
    else if (stallreq_if_i) stall_req = STALL_IF;
    else                    stall_req = STALL_NONE;
  end

  // NOTE: every signal driven here gets a default first, so no path can infer a latch.
  always_comb begin
    state_d  = state_q;
    stall_d  = stall_req;
    flush_d  = 1'b0;
    new_pc_d = '0;
    capture  = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (branch_flag_i && !stallreq_mem_i) begin
          flush_d  = 1'b1;
          new_pc_d = branch_target_i;
          stall_d  = STALL_NONE;
        end else if (branch_flag_i) begin
          capture = 1'b1;
          state_d = HOLD;
        end
      end
      HOLD: begin
        // ex is frozen while we wait, so a repeated branch_flag_i is the same instruction.
        if (!stallreq_mem_i) begin
          flush_d  = 1'b1;
          new_pc_d = target_q;
          stall_d  = STALL_NONE;
          state_d  = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments so all flops sample the same pre-edge values.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q  <= IDLE;
      target_q <= '0;
    end else begin
      state_q <= state_d;
      if (capture) target_q <= branch_target_i;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      run_cnt_q <= '0;
      timeout_q <= 1'b0;
    end else begin
      if (!stallreq_mem_i)          run_cnt_q <= '0;
      else if (run_cnt_q != MAX_CNT) run_cnt_q <= run_cnt_q + 1'b1;
      if (stallreq_mem_i && run_cnt_q == MAX_CNT - 1'b1) timeout_q <= 1'b1;
    end
  end

  // Combinational outputs are forced quiet while reset is held.
  assign stall_o         = rst ? stall_d  : STALL_NONE;
  assign flush_o         = rst ? flush_d  : 1'b0;
  assign new_pc_o        = rst ? new_pc_d : '0;
  assign stall_timeout_o = timeout_q;

`ifdef PIPE_CTRL_PERF_EN
  logic [31:0] perf_stall_q, perf_flush_q;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      perf_stall_q <= '0;
      perf_flush_q <= '0;
    end else begin
      if (stall_o != STALL_NONE) perf_stall_q <= perf_stall_q + 32'd1;
      if (flush_o)               perf_flush_q <= perf_flush_q + 32'd1;
    end
  end

  assign perf_stall_cycles_o = perf_stall_q;
  assign perf_flush_count_o  = perf_flush_q;
`else
  assign perf_stall_cycles_o = 32'h0;
  assign perf_flush_count_o  = 32'h0;
`endif

endmodule

// File: tb/tb_pipe_ctrl.sv
// Scoreboard bench for pipe_ctrl: driver pushes model expectations, monitor pops
// and compares on the falling edge. Perf expectations follow PIPE_CTRL_PERF_EN.
module tb_pipe_ctrl;

  localparam int MAX_STALL = 4;
`ifdef PIPE_CTRL_PERF_EN
  localparam bit PERF_EN = 1'b1;
`else
  localparam bit PERF_EN = 1'b0;
`endif

  logic        clk;
  logic        rst;
  logic        stallreq_if_i, stallreq_id_i, stallreq_mem_i, branch_flag_i;
  logic [31:0] branch_target_i;
  logic [5:0]  stall_o;
  logic        flush_o;
  logic [31:0] new_pc_o;
  logic        stall_timeout_o;
  logic [31:0] perf_stall_cycles_o, perf_flush_count_o;

  pipe_ctrl #(.MAX_STALL(MAX_STALL), .CNT_W(16)) dut (
    .clk                 (clk),
    .rst                 (rst),
    .stallreq_if_i       (stallreq_if_i),
    .stallreq_id_i       (stallreq_id_i),
    .stallreq_mem_i      (stallreq_mem_i),
    .branch_flag_i       (branch_flag_i),
    .branch_target_i     (branch_target_i),
    .stall_o             (stall_o),
    .flush_o             (flush_o),
    .new_pc_o            (new_pc_o),
    .stall_timeout_o     (stall_timeout_o),
    .perf_stall_cycles_o (perf_stall_cycles_o),
    .perf_flush_count_o  (perf_flush_count_o)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct packed {
    logic [5:0]  stall;
    logic        flush;
    logic [31:0] pc;
    logic        tmo;
    logic [31:0] ps;
    logic [31:0] pf;
  } exp_t;

  exp_t sb_q[$];
  int   n_chk  = 0;
  int   n_fail = 0;

  // Reference model: pending redirects as a queue, stall run as a plain integer.
  logic [31:0] pend_q[$];
  int          m_run = 0;
  bit          m_tmo = 1'b0;
  logic [31:0] m_ps = '0, m_pf = '0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s at %0t: got %h, expected %h", name, $time, act, exp);
    end
  endtask

  task automatic step(input bit r, input bit i_if, input bit i_id, input bit i_mem,
                      input bit br, input logic [31:0] tgt);
    exp_t e;
    @(posedge clk);
    #1;
    rst             = r;
    stallreq_if_i   = i_if;
    stallreq_id_i   = i_id;
    stallreq_mem_i  = i_mem;
    branch_flag_i   = br;
    branch_target_i = tgt;
    e = '0;
    if (!r) begin
      pend_q.delete();
      m_run = 0;
      m_tmo = 1'b0;
      m_ps  = '0;
      m_pf  = '0;
    end else begin
      e.tmo   = m_tmo;
      e.ps    = PERF_EN ? m_ps : 32'h0;
      e.pf    = PERF_EN ? m_pf : 32'h0;
      e.stall = i_mem ? 6'b011111 : i_id ? 6'b000111 : i_if ? 6'b000011 : 6'b000000;
      if (pend_q.size() != 0) begin
        if (!i_mem) begin
          e.flush = 1'b1;
          e.pc    = pend_q.pop_front();
        end
      end else if (br) begin
        if (!i_mem) begin
          e.flush = 1'b1;
          e.pc    = tgt;
        end else begin
          pend_q.push_back(tgt);
        end
      end
      if (e.flush) e.stall = 6'b000000;
      m_run = i_mem ? ((m_run < MAX_STALL) ? m_run + 1 : m_run) : 0;
      if (m_run >= MAX_STALL) m_tmo = 1'b1;
      if (e.stall != 6'b000000) m_ps = m_ps + 32'd1;
      if (e.flush)              m_pf = m_pf + 32'd1;
    end
    sb_q.push_back(e);
  endtask

  task automatic idle(input int n);
    for (int k = 0; k < n; k++) step(1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 32'h0);
  endtask

  task automatic do_reset();
    step(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 32'h0);
    step(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 32'h0);
  endtask

  // Monitor: the DUT presents a response every cycle; compare mid-cycle.
  initial begin
    exp_t e;
    forever begin
      @(negedge clk);
      if (sb_q.size() > 0) begin
        e = sb_q.pop_front();
        check("stall_o",             32'(stall_o),        32'(e.stall));
        check("flush_o",             32'(flush_o),        32'(e.flush));
        check("new_pc_o",            new_pc_o,            e.pc);
        check("stall_timeout_o",     32'(stall_timeout_o), 32'(e.tmo));
        check("perf_stall_cycles_o", perf_stall_cycles_o, e.ps);
        check("perf_flush_count_o",  perf_flush_count_o,  e.pf);
      end
    end
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit expired");
    $fatal(1, "watchdog");
  end

  initial begin
    rst = 1'b0;
    stallreq_if_i = 1'b0; stallreq_id_i = 1'b0; stallreq_mem_i = 1'b0;
    branch_flag_i = 1'b0; branch_target_i = '0;

    // Reset, then idle with no requests.
    do_reset();
    idle(2);

    // Priority: id+if, then mem on top.
    step(1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 32'h0);
    step(1'b1, 1'b1, 1'b1, 1'b1, 1'b0, 32'h0);
    idle(1);

    // Immediate redirect overriding an id stall.
    step(1'b1, 1'b0, 1'b1, 1'b0, 1'b1, 32'h0000_0100);
    idle(1);

    // Deferred redirect: target captured once, single flush on release.
    step(1'b1, 1'b0, 1'b0, 1'b1, 1'b1, 32'h0000_2000);
    step(1'b1, 1'b0, 1'b0, 1'b1, 1'b1, 32'h0000_DEAD);
    step(1'b1, 1'b0, 1'b0, 1'b1, 1'b1, 32'h0000_DEAD);
    step(1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 32'h0000_DEAD);
    idle(2);

    // Timeout after MAX_STALL cycles, sticky after the stall ends.
    do_reset();
    for (int k = 0; k < MAX_STALL; k++) step(1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 32'h0);
    idle(3);
    // One cycle short of the limit never sets the flag.
    do_reset();
    for (int k = 0; k < MAX_STALL - 1; k++) step(1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 32'h0);
    idle(3);

    // Reset while HOLD discards the pending redirect; then perf counting.
    step(1'b1, 1'b0, 1'b0, 1'b1, 1'b1, 32'h0000_0300);
    step(1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 32'h0);
    do_reset();
    idle(2);
    step(1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 32'h0);
    step(1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 32'h0);
    step(1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 32'h0000_0400);
    idle(2);

    // Randomised traffic with long mem-stall runs and occasional resets.
    for (int k = 0; k < 600; k++) begin
      step($urandom_range(0, 99) != 0,
           $urandom_range(0, 3) == 0,
           $urandom_range(0, 3) == 0,
           $urandom_range(0, 9) < 6,
           $urandom_range(0, 3) == 0,
           $urandom());
    end
    idle(2);

    @(negedge clk);
    #1;
    check("scoreboard_drain", 32'(sb_q.size()), 32'd0);
    $display("== %0d vectors applied, %0d miscompares ==", n_chk, n_fail);
    $finish;
  end

endmodule
